// File: rtl/isa_pkg.sv
// isa_pkg: operation IDs, opcode/field constants and decode helpers for the 16-bit CPU.
package isa_pkg;
  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_LHI, OP_LLI, OP_LDR, OP_STR,
    OP_CMP, OP_ADDI, OP_SUBI, OP_MOV, OP_BEQ, OP_BNE, OP_BCS, OP_BCC, OP_BAL,
    OP_JMP, OP_JAL_L, OP_JAL_R, OP_JR, OP_OUTR, OP_HLT
  } op_e;
  localparam logic [4:0] OPC_ALU  = 5'b00000;
  localparam logic [4:0] OPC_LHI  = 5'b00001;
  localparam logic [4:0] OPC_LLI  = 5'b00010;
  localparam logic [4:0] OPC_LDR  = 5'b00011;
  localparam logic [4:0] OPC_STR  = 5'b00101;
  localparam logic [4:0] OPC_CMP  = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b00111;
  localparam logic [4:0] OPC_SUBI = 5'b01000;
  localparam logic [4:0] OPC_MOV  = 5'b01011;
  localparam logic [4:0] OPC_JMP  = 5'b10000;
  localparam logic [4:0] OPC_JALL = 5'b10001;
  localparam logic [4:0] OPC_JALR = 5'b10010;
  localparam logic [4:0] OPC_JR   = 5'b10011;
  localparam logic [4:0] OPC_BCC  = 5'b11000;
  localparam logic [4:0] OPC_BAL  = 5'b11001;
  localparam logic [4:0] OPC_SYS  = 5'b11100;
  localparam int OPC_LSB = 11;
  localparam int RD_LSB  = 8;
  localparam int RM_LSB  = 5;
  localparam int RN_LSB  = 2;
  typedef struct packed {
    op_e  op;
    logic illegal;
  } dec_t;
  // No encoding decodes to NOP, so NOP doubles as the illegal marker.
  function automatic dec_t decode_op(input logic [15:0] inst);
    logic [1:0] s;
    logic [2:0] c;
    op_e op;
    s = inst[1:0];
    c = inst[RD_LSB +: 3];
    case (inst[OPC_LSB +: 5])
      OPC_ALU:  op = s == 2'd0 ? OP_ADD : s == 2'd1 ? OP_ADC : s == 2'd2 ? OP_SUB : OP_SBB;
      OPC_LHI:  op = OP_LHI;
      OPC_LLI:  op = OP_LLI;
      OPC_LDR:  op = OP_LDR;
      OPC_STR:  op = OP_STR;
      OPC_CMP:  op = s == 2'd1 ? OP_CMP : OP_NOP;
      OPC_ADDI: op = OP_ADDI;
      OPC_SUBI: op = OP_SUBI;
      OPC_MOV:  op = OP_MOV;
      OPC_JMP:  op = OP_JMP;
      OPC_JALL: op = OP_JAL_L;
      OPC_JALR: op = OP_JAL_R;
      OPC_JR:   op = OP_JR;
      OPC_BCC:  op = c == 3'd0 ? OP_BEQ : c == 3'd1 ? OP_BNE : c == 3'd2 ? OP_BCS : c == 3'd3 ? OP_BCC : OP_NOP;
      OPC_BAL:  op = c == 3'd6 ? OP_BAL : OP_NOP;
      OPC_SYS:  op = s == 2'd0 ? OP_OUTR : s == 2'd1 ? OP_HLT : OP_NOP;
      default:  op = OP_NOP;
    endcase
    return '{op: op, illegal: op == OP_NOP};
  endfunction
  // Every result fits in 16 bits with bit 15 as a valid sign, so callers sign-extend to any width.
  function automatic logic [15:0] ext_imm(input logic [15:0] inst, input op_e op);
    case (op)
      OP_LHI, OP_LLI, OP_MOV, OP_ADDI, OP_SUBI: return {8'h00, inst[7:0]};
      OP_LDR, OP_STR:                           return {11'h000, inst[4:0]};
      OP_BEQ, OP_BNE, OP_BCS, OP_BCC, OP_BAL:   return {{8{inst[7]}}, inst[7:0]};
      OP_JMP, OP_JAL_L:                         return {{5{inst[10]}}, inst[10:0]};
      default:                                  return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/inst_decode_stage_if.sv
// inst_decode_stage_if: fetch-side and execute-side handshake plus status of the decode stage.
interface inst_decode_stage_if #(parameter int DATA_W = 16, parameter int CNT_W = 16);
  import isa_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  op_e               out_op;
  logic [2:0]        out_rd;
  logic [2:0]        out_rm;
  logic [2:0]        out_rn;
  logic [DATA_W-1:0] out_imm;
  logic              out_illegal;
  logic              halted;
  logic [CNT_W-1:0]  dec_count;
  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rm, out_rn, out_imm, out_illegal, halted, dec_count
  );
  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rm, out_rn, out_imm, out_illegal, halted, dec_count
  );
endinterface

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: two-entry valid/ready register slice with flush; skid entry optional.
module decode_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;
  logic         pop;
  assign in_ready = ~hold & (SKID_EN ? ~skid_valid : (~out_valid | out_ready));
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready;
  // With the skid enabled a push implies the skid is empty, so it never refills while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (~out_valid | pop) begin
      out_valid  <= skid_valid | push;
      skid_valid <= 1'b0;
      if (skid_valid) out_data <= skid_data;
      else if (push) out_data <= in_data;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: registered instruction decode with skid buffer, flush, sticky halt and counter.
module inst_decode_stage
  import isa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  inst_decode_stage_if.slave bus
);
  localparam int PW = 5 + 9 + DATA_W + 1;
  dec_t             dec;
  logic [15:0]      imm16;
  logic [PW-1:0]    in_data;
  logic [PW-1:0]    out_data;
  logic             halted;
  logic [CNT_W-1:0] cnt;
  logic             done;
  assign dec     = decode_op(bus.in_inst);
  assign imm16   = ext_imm(bus.in_inst, dec.op);
  assign in_data = {dec.op, bus.in_inst[RD_LSB +: 3], bus.in_inst[RM_LSB +: 3], bus.in_inst[RN_LSB +: 3],
                    DATA_W'($signed(imm16)), dec.illegal};
  decode_skid_buf #(.W(PW), .SKID_EN(SKID_EN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .hold      (halted),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );
  assign bus.out_op      = op_e'(out_data[PW-1 -: 5]);
  assign bus.out_rd      = out_data[PW-6 -: 3];
  assign bus.out_rm      = out_data[PW-9 -: 3];
  assign bus.out_rn      = out_data[PW-12 -: 3];
  assign bus.out_imm     = out_data[DATA_W:1];
  assign bus.out_illegal = out_data[0];
  assign bus.halted      = halted;
  assign bus.dec_count   = cnt;
  assign done = bus.out_valid & bus.out_ready & ~bus.flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
      cnt    <= '0;
    end else begin
      halted <= halted | (done & (bus.out_op == OP_HLT));
      cnt    <= cnt + CNT_W'(done);
    end
  end
endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: directed and random stimulus against a queue-based reference of the decode stage.
module tb_inst_decode_stage;
  localparam int DW = 32;
  localparam int CW = 16;
  typedef struct {
    int            op;
    int            rd;
    int            rm;
    int            rn;
    logic [DW-1:0] imm;
    bit            ill;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  inst_decode_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
  inst_decode_stage #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  int checks = 0;
  int errors = 0;
  ent_t q[$];
  bit m_halt = 1'b0;
  int unsigned m_cnt = 0;
  bit started = 1'b0;
  bit m_rdy;
  int opcs[16] = '{0, 1, 2, 3, 5, 6, 7, 8, 11, 24, 25, 16, 17, 18, 19, 28};
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  // Reference decode: op numbers follow the ISA listing order with NOP = 0.
  function automatic ent_t ref_dec(input logic [15:0] i);
    ent_t e;
    int opc, s, c;
    longint imm;
    opc = int'(i[15:11]);
    s   = int'(i[1:0]);
    c   = int'(i[10:8]);
    imm = 0;
    e.op = 0;
    if (opc == 0) e.op = 1 + s;
    else if (opc == 1 || opc == 2) begin e.op = opc + 4; imm = longint'(i[7:0]); end
    else if (opc == 3) begin e.op = 7; imm = longint'(i[4:0]); end
    else if (opc == 5) begin e.op = 8; imm = longint'(i[4:0]); end
    else if (opc == 6 && s == 1) e.op = 9;
    else if (opc == 7 || opc == 8) begin e.op = opc + 3; imm = longint'(i[7:0]); end
    else if (opc == 11) begin e.op = 12; imm = longint'(i[7:0]); end
    else if ((opc == 24 && c < 4) || (opc == 25 && c == 6)) begin
      e.op = opc == 24 ? 13 + c : 17;
      imm = i[7] ? longint'(i[7:0]) - 256 : longint'(i[7:0]);
    end else if (opc >= 16 && opc <= 19) begin
      e.op = opc + 2;
      if (opc <= 17) imm = i[10] ? longint'(i[10:0]) - 2048 : longint'(i[10:0]);
    end else if (opc == 28 && s < 2) e.op = 22 + s;
    e.rd  = c;
    e.rm  = int'(i[7:5]);
    e.rn  = int'(i[4:2]);
    e.ill = e.op == 0;
    e.imm = imm[DW-1:0];
    return e;
  endfunction
  always @(posedge clk) begin
    m_rdy = !m_halt && q.size() < 2;
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_halt = 1'b0;
      m_cnt = 0;
    end else if (bus.flush) q.delete();
    else begin
      if (q.size() > 0 && bus.out_ready) begin
        if (q[0].op == 23) m_halt = 1'b1;
        m_cnt++;
        void'(q.pop_front());
      end
      if (bus.in_valid && m_rdy) q.push_back(ref_dec(bus.in_inst));
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", bus.in_ready, 64'(!m_halt && q.size() < 2));
      chk("out_valid", bus.out_valid, 64'(q.size() > 0));
      chk("halted", bus.halted, 64'(m_halt));
      chk("dec_count", bus.dec_count, 64'(m_cnt[CW-1:0]));
      if (q.size() > 0) begin
        chk("op", bus.out_op, 64'(q[0].op));
        chk("rd", bus.out_rd, 64'(q[0].rd));
        chk("rm", bus.out_rm, 64'(q[0].rm));
        chk("rn", bus.out_rn, 64'(q[0].rn));
        chk("imm", bus.out_imm, 64'(q[0].imm));
        chk("illegal", bus.out_illegal, 64'(q[0].ill));
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic logic [15:0] pick();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 9) < 7) v[15:11] = 5'(opcs[$urandom_range(0, 15)]);
    return v;
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.in_inst = 16'h0000;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_count", bus.dec_count, 0);
    chk("rst_op", bus.out_op, 0);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_rd", bus.out_rd, 0);
    chk("rst_illegal", bus.out_illegal, 0);
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_inst = 16'h014C; tick();
    bus.in_valid = 1'b0;
    chk("add_op", bus.out_op, 1);
    chk("add_rd", bus.out_rd, 1);
    chk("add_rm", bus.out_rm, 2);
    chk("add_rn", bus.out_rn, 3);
    chk("add_imm", bus.out_imm, 0);
    chk("add_ill", bus.out_illegal, 0);
    tick();
    chk("add_count", bus.dec_count, 1);
    bus.in_valid = 1'b1; bus.in_inst = 16'hC0FE; tick();
    chk("beq_op", bus.out_op, 13);
    chk("beq_imm", bus.out_imm, 64'hFFFF_FFFE);
    bus.in_inst = 16'h87FF; tick();
    chk("jmp_op", bus.out_op, 18);
    chk("jmp_imm", bus.out_imm, 64'hFFFF_FFFF);
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_inst = 16'hF800; tick();
    bus.in_valid = 1'b0;
    chk("ill_flag", bus.out_illegal, 1);
    chk("ill_op", bus.out_op, 0);
    tick();
    chk("ill_count", bus.dec_count, 4);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_inst = 16'h014C; tick();
    bus.in_inst = 16'h0AAB; tick();
    chk("full_in_ready", bus.in_ready, 0);
    bus.flush = 1'b1; bus.in_inst = 16'hC0FE; tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_count", bus.dec_count, 4);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_inst = 16'h0AAB; tick();
    bus.in_valid = 1'b0;
    chk("post_flush_op", bus.out_op, 5);
    chk("post_flush_imm", bus.out_imm, 64'h00AB);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_inst = 16'h0AAB; tick();
    bus.in_inst = 16'h014C; tick();
    chk("stall_in_ready", bus.in_ready, 0);
    bus.in_inst = 16'hE001; tick();
    chk("stall_op", bus.out_op, 5);
    chk("stall_imm", bus.out_imm, 64'h00AB);
    bus.out_ready = 1'b1; tick();
    chk("drain_add", bus.out_op, 1);
    tick();
    chk("drain_hlt", bus.out_op, 23);
    bus.in_valid = 1'b0; tick();
    chk("halt_set", bus.halted, 1);
    chk("halt_ready", bus.in_ready, 0);
    chk("halt_count", bus.dec_count, 8);
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    chk("halt_flush", bus.halted, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("halt_rst", bus.halted, 0);
    chk("halt_rst_ready", bus.in_ready, 1);
    for (int n = 0; n < 4000; n++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.flush     = $urandom_range(0, 39) == 0;
      rst           = $urandom_range(0, 99) == 0;
      bus.in_inst   = pick();
      tick();
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
